tx_data_packer: RTL and testbench
=================================

TX_DATA_PACKER -- requirements
Module: tx_data_packer

Interface
REQ-001 Parameter AXI_DW, default 32, write-data beat width in bits; legal values 32 or 64.
REQ-002 Parameter LEN_W, default 8, width of the transaction length field.
REQ-003 Derived constant HW_PER_BEAT = AXI_DW/16, the number of 16-bit halfwords per beat.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 trans_valid_i  input  1  new write transaction descriptor offered.
REQ-007 trans_ready_o  output  1  descriptor accepted when high together with trans_valid_i.
REQ-008 trans_len_i  input  LEN_W  halfword count minus one.
REQ-009 trans_offset_i  input  $clog2(HW_PER_BEAT)  starting halfword index within the first beat.
REQ-010 w_data_i  input  AXI_DW  write beat data.
REQ-011 w_strb_i  input  AXI_DW/8  byte strobes.
REQ-012 w_last_i  input  1  beat is the last one of the upstream burst.
REQ-013 w_valid_i / w_ready_o  input / output  1 each  beat handshake.
REQ-014 data_o  output  18  word {mask[1:0], halfword[15:0]} driven toward the output FIFO.
REQ-015 valid_o / ready_i  output / input  1 each  word handshake; ready_i connects to the FIFO ready.
REQ-016 last_o  output  1  high with the final word of a transaction.
REQ-017 done_o  output  1  one-cycle pulse after the final word is transferred.
REQ-018 error_o  output  1  sticky error: w_last_i seen while halfwords remain.

Function
REQ-019 The FSM SHALL have states IDLE and ACTIVE only.
REQ-020 IDLE: trans_ready_o=1 and w_ready_o=0; on trans_valid_i, load remaining=trans_len_i, idx=trans_offset_i, clear error_o, enter ACTIVE.
REQ-021 ACTIVE: trans_ready_o=0; the beat register holds one beat; w_ready_o = ~beat_valid | (word handshake consuming the last halfword of the beat while remaining!=0).
REQ-022 valid_o SHALL equal beat_valid in ACTIVE and be 0 in IDLE; data_o[15:0] = beat halfword idx.
REQ-023 Mask bits: see Configuration.
REQ-024 data_o, last_o SHALL be held stable while valid_o=1 and ready_i=0.
REQ-025 On a word handshake: remaining decrements; idx increments and wraps to 0 after HW_PER_BEAT-1; beat_valid clears at wrap unless refilled in the same cycle (zero-bubble refill).
REQ-026 last_o = valid_o & (remaining==0); the handshake with last_o SHALL return the FSM to IDLE, discard unused halfwords of the beat, and pulse done_o on the next cycle.
REQ-027 A beat accepted with w_last_i=1 while more halfwords than it supplies remain SHALL set error_o; transfer continues.
REQ-028 Sustained throughput SHALL be one word per cycle while ready_i=1 and w_valid_i=1.
REQ-029 A transaction of trans_len_i=0 SHALL emit exactly one word.

Reset
REQ-030 Reset SHALL force IDLE, beat_valid=0, remaining=0, idx=0, and error_o=0; outputs become valid_o=0, last_o=0, done_o=0, w_ready_o=0, trans_ready_o=1, data_o=0.
REQ-031 Reset mid-transaction SHALL drop all buffered data without emitting further words.

Configuration
REQ-032 Macro HYPER_TX_MASK_EN defined: data_o[17:16] = ~strb bits of the selected halfword (1 = byte masked).
REQ-033 HYPER_TX_MASK_EN undefined: data_o[17:16]=2'b00, w_strb_i is ignored, and no strobe storage is instantiated.

Structure
REQ-034 Package hyper_tx_pkg SHALL hold the state enum, HW_WIDTH=16, MASK_WIDTH=2, and OUT_WIDTH=18.
REQ-035 No sub-module; the halfword/strobe select is an inline mux.

Verification
REQ-036 AXI_DW=32, len=3, offset=0, beats 0xBBBBAAAA and 0xDDDDCCCC with full strobes, ready_i=1 -> words 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD on four consecutive cycles, last_o on 0xDDDD, done_o the next cycle.
REQ-037 Same stimulus with ready_i low on cycles 2-4 -> data_o and last_o held, no word lost or duplicated.
REQ-038 len=0, offset=1, beat 0x1234_5678 -> single word 0x1234 with last_o=1; 0x5678 is never emitted.
REQ-039 MASK_EN, strb=4'b0110 -> mask 2'b01 on low halfword and 2'b10 on high halfword; with the macro off -> 2'b00 on both.
REQ-040 len=5 with w_last_i set on the second beat -> error_o=1 from the next cycle; held until the next descriptor is accepted.
REQ-041 Assert rst_ni low after the second word of a len=7 transfer -> valid_o=0 immediately, and trans_ready_o=1 after release.

Source files
------------

// File: rtl/tx_data_packer_pkg.sv
// Shared constants and FSM encoding for the TX halfword packer.
// Defining HYPER_TX_MASK_EN enables the byte-mask bits in the output word.
package hyper_tx_pkg;

  localparam int HW_WIDTH   = 16;
  localparam int MASK_WIDTH = 2;
  localparam int OUT_WIDTH  = HW_WIDTH + MASK_WIDTH;

  typedef logic [0:0] state_t;

  localparam state_t IDLE   = 1'b0;
  localparam state_t ACTIVE = 1'b1;

endpackage

// File: rtl/tx_data_packer_if.sv
// Descriptor, write-beat and output-word handshakes of the TX packer.
// The master modport is the environment side, slave is the packer.
interface tx_data_packer_if
  import hyper_tx_pkg::*;
#(
  parameter int AXI_DW = 32,
  parameter int LEN_W  = 8
) ();

  localparam int HW_PER_BEAT = AXI_DW / HW_WIDTH;
  localparam int OFF_W       = $clog2(HW_PER_BEAT);

  logic                 trans_valid_i;
  logic                 trans_ready_o;
  logic [LEN_W-1:0]     trans_len_i;
  logic [OFF_W-1:0]     trans_offset_i;

  logic [AXI_DW-1:0]    w_data_i;
  logic [AXI_DW/8-1:0]  w_strb_i;
  logic                 w_last_i;
  logic                 w_valid_i;
  logic                 w_ready_o;

  logic [OUT_WIDTH-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 last_o;
  logic                 done_o;
  logic                 error_o;

  modport master (
    output trans_valid_i, trans_len_i, trans_offset_i,
    output w_data_i, w_strb_i, w_last_i, w_valid_i,
    output ready_i,
    input  trans_ready_o, w_ready_o,
    input  data_o, valid_o, last_o, done_o, error_o
  );

  modport slave (
    input  trans_valid_i, trans_len_i, trans_offset_i,
    input  w_data_i, w_strb_i, w_last_i, w_valid_i,
    input  ready_i,
    output trans_ready_o, w_ready_o,
    output data_o, valid_o, last_o, done_o, error_o
  );

endinterface

// File: rtl/tx_data_packer.sv
// Splits AXI write beats into 18-bit {mask, halfword} words for the TX FIFO.
// Optional feature: HYPER_TX_MASK_EN drives inverted strobes as mask bits.
module tx_data_packer
  import hyper_tx_pkg::*;
#(
  parameter int AXI_DW = 32,
  parameter int LEN_W  = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  tx_data_packer_if.slave bus
);

  localparam int HW_PER_BEAT = AXI_DW / HW_WIDTH;
  localparam int IDX_W       = $clog2(HW_PER_BEAT);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(HW_PER_BEAT - 1);
  localparam logic [IDX_W:0]   HW_CNT  = (IDX_W+1)'(HW_PER_BEAT);

  state_t                              state_q;
  logic [HW_PER_BEAT-1:0][HW_WIDTH-1:0] beat_q;
  logic                                beat_valid_q;
  logic [LEN_W-1:0]                    rem_q;
  logic [IDX_W-1:0]                    idx_q;
  logic                                err_q;
  logic                                done_q;

  logic                  active;
  logic                  rem_zero;
  logic                  last_hw;
  logic                  word_hs;
  logic                  beat_hs;
  logic                  err_set;
  logic [LEN_W-1:0]      eff_rem;
  logic [IDX_W:0]        supplied;
  logic [MASK_WIDTH-1:0] mask;

  assign active   = (state_q == ACTIVE);
  assign rem_zero = (rem_q == '0);
  assign last_hw  = (idx_q == IDX_MAX);

  assign bus.trans_ready_o = ~active;
  assign bus.valid_o       = active & beat_valid_q;
  assign bus.last_o        = bus.valid_o & rem_zero;
  assign bus.done_o        = done_q;
  assign bus.error_o       = err_q;

  assign word_hs = bus.valid_o & bus.ready_i;

  // Refill in the same cycle the last halfword leaves keeps one word per cycle.
  assign bus.w_ready_o = active &
    (~beat_valid_q | (word_hs & last_hw & ~rem_zero));
  assign beat_hs = bus.w_valid_i & bus.w_ready_o;

  // Halfwords still owed when the new beat starts versus what it holds.
  assign eff_rem  = word_hs ? rem_q - LEN_W'(1) : rem_q;
  assign supplied = word_hs ? HW_CNT : HW_CNT - {1'b0, idx_q};
  assign err_set  = beat_hs & bus.w_last_i &
    (32'(eff_rem) >= 32'(supplied));

`ifdef HYPER_TX_MASK_EN
  logic [HW_PER_BEAT-1:0][MASK_WIDTH-1:0] strb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strb_q <= '0;
    end else if (beat_hs) begin
      strb_q <= bus.w_strb_i;
    end
  end

  assign mask = ~strb_q[idx_q];
`else
  assign mask = '0;
`endif

  assign bus.data_o = bus.valid_o ? {mask, beat_q[idx_q]} : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      beat_valid_q <= 1'b0;
      rem_q        <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= word_hs & bus.last_o;
      unique case (state_q)
        IDLE: begin
          if (bus.trans_valid_i) begin
            rem_q        <= bus.trans_len_i;
            idx_q        <= bus.trans_offset_i;
            err_q        <= 1'b0;
            beat_valid_q <= 1'b0;
            state_q      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (beat_hs) begin
            beat_q       <= bus.w_data_i;
            beat_valid_q <= 1'b1;
          end
          if (err_set) begin
            err_q <= 1'b1;
          end
          if (word_hs) begin
            if (rem_zero) begin
              state_q      <= IDLE;
              beat_valid_q <= 1'b0;
              rem_q        <= '0;
              idx_q        <= '0;
            end else begin
              rem_q <= rem_q - LEN_W'(1);
              idx_q <= last_hw ? '0 : idx_q + IDX_W'(1);
              if (last_hw & ~beat_hs) begin
                beat_valid_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_data_packer.sv
// Scoreboard bench for tx_data_packer at AXI_DW=32.
// Expected mask bits follow HYPER_TX_MASK_EN.
module tb_tx_data_packer;
  import hyper_tx_pkg::*;

  localparam int AXI_DW = 32;
  localparam int LEN_W  = 8;

  logic clk;
  logic rst_ni;
  int   cyc;

  tx_data_packer_if #(.AXI_DW(AXI_DW), .LEN_W(LEN_W)) bus ();

  tx_data_packer #(.AXI_DW(AXI_DW), .LEN_W(LEN_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               tag, obs, exp, cyc);
    end
  endtask

  logic [18:0] exp_q[$];
  int          hs_cycs[$];
  int          last_cyc;
  int          done_cnt;
  int          exp_done;
  logic [31:0] bd[8];
  logic [3:0]  bs[8];
  bit          rdy_rand;
  logic [15:0] rdy_pat;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) begin
        bus.ready_i = 1'($urandom_range(0, 1));
      end else begin
        bus.ready_i = rdy_pat[0];
        rdy_pat     = {1'b1, rdy_pat[15:1]};
      end
    end
  end

  initial begin
    logic        stall_q;
    logic [17:0] hold_d;
    logic        hold_l;
    logic [18:0] e;
    stall_q = 1'b0;
    hold_d  = '0;
    hold_l  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_valid", 32'(bus.valid_o), 32'd1);
          check("hold_data", 32'(bus.data_o), 32'(hold_d));
          check("hold_last", 32'(bus.last_o), 32'(hold_l));
        end
        if (bus.valid_o && bus.ready_i) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 32'(bus.data_o), 32'hDEAD_0000);
          end else begin
            e = exp_q.pop_front();
            check("word_data", 32'(bus.data_o), 32'(e[17:0]));
            check("word_last", 32'(bus.last_o), 32'(e[18]));
          end
          hs_cycs.push_back(cyc);
          if (bus.last_o) last_cyc = cyc;
        end
        if (bus.done_o) begin
          done_cnt++;
          check("done_lat", 32'(cyc - last_cyc), 32'd1);
        end
        stall_q = bus.valid_o & ~bus.ready_i;
        hold_d  = bus.data_o;
        hold_l  = bus.last_o;
      end
    end
  end

  task automatic push_exp(input int len, input int off);
    int          idx;
    int          b;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  m;
    idx = off;
    b   = 0;
    for (int n = 0; n <= len; n++) begin
      d = bd[b];
      s = bs[b];
`ifdef HYPER_TX_MASK_EN
      m = ~s[2*idx +: 2];
`else
      m = 2'b00;
`endif
      exp_q.push_back({(n == len), m, d[16*idx +: 16]});
      idx++;
      if (idx == 2) begin
        idx = 0;
        b++;
      end
    end
  endtask

  task automatic send_trans(input int len, input int off);
    bit ok;
    int n;
    bus.trans_len_i    = LEN_W'(len);
    bus.trans_offset_i = 1'(off);
    bus.trans_valid_i  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.trans_ready_o;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    #1;
    bus.trans_valid_i = 1'b0;
    if (!ok) check("trans_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_beat(input logic [31:0] d,
                           input logic [3:0] s,
                           input bit last);
    bit ok;
    int n;
    bus.w_data_i  = d;
    bus.w_strb_i  = s;
    bus.w_last_i  = last;
    bus.w_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.w_ready_o;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    #1;
    bus.w_valid_i = 1'b0;
    if (!ok) check("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.trans_ready_o) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_trans(input int len, input int off,
                           input int nb, input int lastb);
    push_exp(len, off);
    exp_done++;
    send_trans(len, off);
    for (int i = 0; i < nb; i++) begin
      send_beat(bd[i], bs[i], (i == lastb));
    end
    drain();
  endtask

  initial begin
    int len;
    int off;
    int nb;
    checks   = 0;
    failures = 0;
    done_cnt = 0;
    exp_done = 0;
    last_cyc = 0;
    rdy_rand = 1'b0;
    rdy_pat  = 16'hFFFF;
    bus.trans_valid_i  = 1'b0;
    bus.trans_len_i    = '0;
    bus.trans_offset_i = '0;
    bus.w_data_i  = '0;
    bus.w_strb_i  = '0;
    bus.w_last_i  = 1'b0;
    bus.w_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trans_ready", 32'(bus.trans_ready_o), 32'd1);
    check("rst_w_ready", 32'(bus.w_ready_o), 32'd0);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_last", 32'(bus.last_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_error", 32'(bus.error_o), 32'd0);
    check("rst_data", 32'(bus.data_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // four words back to back
    bd[0] = 32'hBBBB_AAAA; bs[0] = 4'hF;
    bd[1] = 32'hDDDD_CCCC; bs[1] = 4'hF;
    hs_cycs.delete();
    run_trans(3, 0, 2, 1);
    check("tput_words", 32'(hs_cycs.size()), 32'd4);
    if (hs_cycs.size() == 4) begin
      check("tput_span", 32'(hs_cycs[3] - hs_cycs[0]), 32'd3);
    end

    // output stalls while words are pending
    rdy_pat = 16'hFFE3;
    run_trans(3, 0, 2, 1);

    // single word from the upper halfword
    bd[0] = 32'h1234_5678; bs[0] = 4'hF;
    run_trans(0, 1, 1, 0);
    check("len0_error", 32'(bus.error_o), 32'd0);

    // early w_last raises sticky error
    bd[0] = 32'h2222_1111; bs[0] = 4'hF;
    bd[1] = 32'h4444_3333; bs[1] = 4'hF;
    bd[2] = 32'h6666_5555; bs[2] = 4'hF;
    push_exp(5, 0);
    exp_done++;
    send_trans(5, 0);
    send_beat(bd[0], bs[0], 1'b0);
    check("err_before", 32'(bus.error_o), 32'd0);
    send_beat(bd[1], bs[1], 1'b1);
    check("err_set", 32'(bus.error_o), 32'd1);
    send_beat(bd[2], bs[2], 1'b0);
    drain();
    check("err_sticky", 32'(bus.error_o), 32'd1);

    // strobe pattern drives mask bits
    bd[0] = 32'h8765_4321; bs[0] = 4'b0110;
    bd[1] = 32'h0FED_CBA9; bs[1] = 4'b0110;
    push_exp(3, 0);
    exp_done++;
    send_trans(3, 0);
    check("err_clear", 32'(bus.error_o), 32'd0);
    send_beat(bd[0], bs[0], 1'b0);
    send_beat(bd[1], bs[1], 1'b1);
    drain();

    // reset in the middle of a transfer
    for (int i = 0; i < 4; i++) begin
      bd[i] = 32'h0100_0001 * (i + 1);
      bs[i] = 4'hF;
    end
    push_exp(7, 0);
    send_trans(7, 0);
    send_beat(bd[0], bs[0], 1'b0);
    send_beat(bd[1], bs[1], 1'b0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    check("mid_rst_data", 32'(bus.data_o), 32'd0);
    check("mid_rst_words", 32'(exp_q.size()), 32'd6);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_tready", 32'(bus.trans_ready_o), 32'd1);
    check("post_rst_wready", 32'(bus.w_ready_o), 32'd0);
    check("post_rst_valid", 32'(bus.valid_o), 32'd0);

    // random lengths, offsets and back-pressure
    rdy_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 9);
      off = $urandom_range(0, 1);
      nb  = (off + len + 2) / 2;
      for (int i = 0; i < nb; i++) begin
        bd[i] = $urandom;
        bs[i] = 4'($urandom);
      end
      run_trans(len, off, nb, nb - 1);
      check("rand_error", 32'(bus.error_o), 32'd0);
    end
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 32'(done_cnt), 32'(exp_done));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
